// File: rtl/uart_tx_cfg_pkg.sv
// Shared typedefs for the configurable UART transmitter: FSM state encoding,
// parity mode constants and a parity helper used when a word is loaded.
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_cfg_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Parity bit for a zero-extended data word: XOR of the bits for even
    // parity, inverted for odd parity.
    function automatic logic parity_of(input logic [8:0] word, input int mode);
        return (^word) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake and serial-line status bundle of the UART transmitter.
// The producer side uses master, the transmitter uses slave.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_valid;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_ready;
    logic                 o_tx_serial;
    logic                 o_tx_busy;
    logic                 o_tx_done;
    logic                 o_tick_debug;

    modport master (
        output i_valid,
        output i_data,
        input  o_ready,
        input  o_tx_serial,
        input  o_tx_busy,
        input  o_tx_done,
        input  o_tick_debug
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_ready,
        output o_tx_serial,
        output o_tx_busy,
        output o_tx_done,
        output o_tick_debug
    );
endinterface

// File: rtl/uart_tx_cfg_baud_tick.sv
// Bit-period timer: counts clock cycles within one serial bit and raises
// tick on the last cycle of the period. restart holds the count at zero so
// the first period after restart is a full CLKS_PER_BIT cycles long.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = !restart && (cnt_reg == LAST);

    // Cycle counter: cleared on restart and at every bit boundary.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-word holding buffer. Words are
// accepted on valid/ready, framed as start, data (LSB first), optional
// parity and stop bits, and sent back-to-back when the buffer is refilled
// during a frame.
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          i_clk,
    input  logic          rst,
    uart_tx_cfg_if.slave  bus
);
    // Reject illegal configurations while elaborating.
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx_cfg: CLKS_PER_BIT must be 2 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam int               BIT_W     = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_cfg_state_t        state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic                 tx_reg;
    logic                 busy_reg;
    logic                 buf_full_reg;
    logic [DATA_BITS-1:0] buf_data_reg;

    logic                 tick;
    logic                 accept;
    logic                 frame_end;
    logic                 start_from_buf;
    logic                 start_direct;
    logic                 start_frame;
    logic [DATA_BITS-1:0] load_data;

    // The timer idles at zero while no frame is on the line.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .rst     (rst),
        .restart (state_reg == ST_IDLE),
        .tick    (tick)
    );

    assign accept    = bus.i_valid && !buf_full_reg;
    assign frame_end = (state_reg == ST_STOP) && tick && (stop_cnt_reg == LAST_STOP);

    // A new frame starts from the buffer when it holds a word, or straight
    // from the input when a word arrives exactly when the line is free; the
    // latter gives one cycle of latency from acceptance to the start bit.
    assign start_from_buf = buf_full_reg && ((state_reg == ST_IDLE) || frame_end);
    assign start_direct   = accept && ((state_reg == ST_IDLE) || frame_end);
    assign start_frame    = start_from_buf || start_direct;
    assign load_data      = buf_full_reg ? buf_data_reg : bus.i_data;

    assign bus.o_ready      = !buf_full_reg;
    assign bus.o_tx_serial  = tx_reg;
    assign bus.o_tx_busy    = busy_reg;
    assign bus.o_tx_done    = frame_end;
    assign bus.o_tick_debug = tick;

    // Holding buffer: fills on acceptance unless the word goes straight into
    // the shift register, empties when its word starts a frame.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            buf_full_reg <= 1'b0;
            buf_data_reg <= '0;
        end else if (start_from_buf) begin
            buf_full_reg <= 1'b0;
        end else if (accept && !start_direct) begin
            buf_full_reg <= 1'b1;
            buf_data_reg <= bus.i_data;
        end
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_frame) begin
                        state_reg <= ST_START;
                        shift_reg <= load_data;
                        par_reg   <= parity_of(9'(load_data), PARITY);
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else begin
                        tx_reg   <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_reg   <= ST_DATA;
                        tx_reg      <= shift_reg[0];
                        bit_cnt_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            if (PARITY != PARITY_NONE) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= par_reg;
                            end else begin
                                state_reg    <= ST_STOP;
                                tx_reg       <= 1'b1;
                                stop_cnt_reg <= 1'b0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state_reg    <= ST_STOP;
                        tx_reg       <= 1'b1;
                        stop_cnt_reg <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (stop_cnt_reg == LAST_STOP) begin
                            if (start_frame) begin
                                state_reg <= ST_START;
                                shift_reg <= load_data;
                                par_reg   <= parity_of(9'(load_data), PARITY);
                                tx_reg    <= 1'b0;
                            end else begin
                                state_reg <= ST_IDLE;
                                tx_reg    <= 1'b1;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            stop_cnt_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Corrupted state: release the line and start over.
                    state_reg    <= ST_IDLE;
                    tx_reg       <= 1'b1;
                    busy_reg     <= 1'b0;
                    bit_cnt_reg  <= '0;
                    stop_cnt_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: four instances at CLKS_PER_BIT=4
// (8N1, 8E1, 8O1, 5N2) driven with directed and random word streams and
// compared cycle by cycle against a frame model built from the bit layout.
module tb_uart_tx_cfg;

    logic i_clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    logic       vld [4];
    logic [8:0] dat [4];
    logic       line_w [4];
    logic       rdy_w  [4];
    logic       busy_w [4];
    logic       done_w [4];
    logic       tick_w [4];

    int cfg_nb  [4] = '{8, 8, 8, 5};
    int cfg_par [4] = '{0, 1, 2, 0};
    int cfg_sb  [4] = '{1, 1, 1, 2};

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_tx_cfg_if #(.DATA_BITS(5)) if3 ();

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_dut0 (.i_clk(i_clk), .rst(rst_n), .bus(if0));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_dut1 (.i_clk(i_clk), .rst(rst_n), .bus(if1));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_dut2 (.i_clk(i_clk), .rst(rst_n), .bus(if2));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2))
        u_dut3 (.i_clk(i_clk), .rst(rst_n), .bus(if3));

    assign if0.i_valid = vld[0];
    assign if0.i_data  = dat[0][7:0];
    assign if1.i_valid = vld[1];
    assign if1.i_data  = dat[1][7:0];
    assign if2.i_valid = vld[2];
    assign if2.i_data  = dat[2][7:0];
    assign if3.i_valid = vld[3];
    assign if3.i_data  = dat[3][4:0];

    assign line_w[0] = if0.o_tx_serial;
    assign line_w[1] = if1.o_tx_serial;
    assign line_w[2] = if2.o_tx_serial;
    assign line_w[3] = if3.o_tx_serial;
    assign rdy_w[0]  = if0.o_ready;
    assign rdy_w[1]  = if1.o_ready;
    assign rdy_w[2]  = if2.o_ready;
    assign rdy_w[3]  = if3.o_ready;
    assign busy_w[0] = if0.o_tx_busy;
    assign busy_w[1] = if1.o_tx_busy;
    assign busy_w[2] = if2.o_tx_busy;
    assign busy_w[3] = if3.o_tx_busy;
    assign done_w[0] = if0.o_tx_done;
    assign done_w[1] = if1.o_tx_done;
    assign done_w[2] = if2.o_tx_done;
    assign done_w[3] = if3.o_tx_done;
    assign tick_w[0] = if0.o_tick_debug;
    assign tick_w[1] = if1.o_tick_debug;
    assign tick_w[2] = if2.o_tick_debug;
    assign tick_w[3] = if3.o_tick_debug;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Cycles per frame: start + data + optional parity + stop bits, 4 clocks each.
    function automatic int frame_cycles(input int inst);
        return 4 * (1 + cfg_nb[inst] + ((cfg_par[inst] != 0) ? 1 : 0) + cfg_sb[inst]);
    endfunction

    // Line level at offset pos (0-based clock) inside a frame carrying word.
    function automatic logic model_bit(input int inst, input int word, input int pos);
        int b;
        int ones;
        b = pos / 4;
        if (b == 0) return 1'b0;
        if (b <= cfg_nb[inst]) return ((word >> (b - 1)) & 1) != 0;
        if (cfg_par[inst] != 0 && b == cfg_nb[inst] + 1) begin
            ones = $countones(word);
            return (cfg_par[inst] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        end
        return 1'b1;
    endfunction

    // Clock edge (counted from the first offer) on which word j is taken.
    function automatic int acc_cycle(input int j, input int f);
        if (j == 0) return 0;
        if (j == 1) return 1;
        return (j - 1) * f + 1;
    endfunction

    // Buffer is empty unless some queued word j>=1 waits in it.
    function automatic logic ready_model(input int c, input int n, input int f);
        for (int j = 1; j < n; j++) begin
            if (acc_cycle(j, f) < c && c <= j * f) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Offer n words with valid held (garbage data while the buffer is full)
    // and check every output on every cycle until the line is idle again.
    task automatic run_stream(input int inst, input int n, input int w[4], input string tag);
        int   f;
        int   nxt;
        logic lb;
        f = frame_cycles(inst);
        vld[inst] = 1'b1;
        dat[inst] = 9'(w[0]);
        nxt = 1;
        for (int c = 1; c <= n * f + 2; c++) begin
            @(negedge i_clk);
            lb = (c <= n * f) ? model_bit(inst, w[(c - 1) / f], (c - 1) % f) : 1'b1;
            chk($sformatf("%s line c=%0d", tag, c), line_w[inst], lb);
            chk($sformatf("%s busy c=%0d", tag, c), busy_w[inst], c <= n * f);
            chk($sformatf("%s done c=%0d", tag, c), done_w[inst], (c <= n * f) && (c % f == 0));
            chk($sformatf("%s tick c=%0d", tag, c), tick_w[inst], (c <= n * f) && (c % 4 == 0));
            chk($sformatf("%s ready c=%0d", tag, c), rdy_w[inst], ready_model(c, n, f));
            if (nxt < n) begin
                vld[inst] = 1'b1;
                if (c == acc_cycle(nxt, f)) begin
                    dat[inst] = 9'(w[nxt]);
                    nxt++;
                end else begin
                    dat[inst] = 9'($urandom_range(0, 511));
                end
            end else begin
                vld[inst] = 1'b0;
            end
        end
        vld[inst] = 1'b0;
        $display("stream %s: %0d word(s) first=%0h checked through cycle %0d", tag, n, w[0], n * f + 2);
    endtask

    initial begin
        int w[4];
        int n;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0;
            dat[i] = '0;
        end

        // Reset values while rst is held low.
        repeat (3) @(negedge i_clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset line u%0d", i), line_w[i], 1'b1);
            chk($sformatf("reset ready u%0d", i), rdy_w[i], 1'b1);
            chk($sformatf("reset busy u%0d", i), busy_w[i], 1'b0);
            chk($sformatf("reset done u%0d", i), done_w[i], 1'b0);
            chk($sformatf("reset tick u%0d", i), tick_w[i], 1'b0);
        end
        $display("reset state checked on 4 instances");

        // First offer right after release is taken on the first edge.
        rst_n = 1'b1;
        w = '{32'hA5, 0, 0, 0};
        run_stream(0, 1, w, "8N1_A5");
        w = '{32'h07, 0, 0, 0};
        run_stream(1, 1, w, "8E1_07");
        run_stream(2, 1, w, "8O1_07");
        w = '{32'h1F, 0, 0, 0};
        run_stream(3, 1, w, "5N2_1F");

        // Back-to-back with valid held, third word offered as soon as the
        // buffer frees up.
        w = '{32'h55, 32'h33, int'($urandom_range(0, 255)), 0};
        run_stream(0, 3, w, "8N1_b2b");

        // Random streams on every configuration.
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 2; r++) begin
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < 4; k++) w[k] = int'($urandom_range(0, (1 << cfg_nb[i]) - 1));
                run_stream(i, n, w, $sformatf("rand_u%0d_%0d", i, r));
            end
        end

        // Reset in the middle of data bit 3.
        vld[0] = 1'b1;
        dat[0] = 9'h3C;
        for (int c = 1; c <= 18; c++) begin
            @(negedge i_clk);
            vld[0] = 1'b0;
        end
        chk("pre-reset data bit 3", line_w[0], model_bit(0, 32'h3C, 17));
        rst_n = 1'b0;
        #1;
        chk("abort line", line_w[0], 1'b1);
        chk("abort ready", rdy_w[0], 1'b1);
        chk("abort busy", busy_w[0], 1'b0);
        chk("abort done", done_w[0], 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            chk($sformatf("abort hold done c=%0d", c), done_w[0], 1'b0);
            chk($sformatf("abort hold line c=%0d", c), line_w[0], 1'b1);
        end
        $display("mid-frame reset checked");
        rst_n = 1'b1;
        w = '{32'h81, 0, 0, 0};
        run_stream(0, 1, w, "8N1_81_after_reset");

        repeat (2) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868: clock cycles per serial bit; legal values are 2 and above.
REQ-002 SHALL provide parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL provide parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_valid, input, width 1: a data word is offered.
REQ-008 SHALL have port i_data, input, width DATA_BITS: the offered word.
REQ-009 SHALL have port o_ready, output, width 1: the block can accept a word.
REQ-010 SHALL have port o_tx_serial, output, width 1: serial line; idles high.
REQ-011 SHALL have port o_tx_busy, output, width 1: a frame is on the line.
REQ-012 SHALL have port o_tx_done, output, width 1: one-cycle pulse at the end of each frame.
REQ-013 SHALL have port o_tick_debug, output, width 1: one-cycle pulse on the last cycle of every bit period.

Function
REQ-014 SHALL accept a word on any cycle where i_valid and o_ready are both high; i_data is ignored on all other cycles.
REQ-015 SHALL capture each accepted word into a one-entry holding buffer; o_ready SHALL be high exactly when that buffer is empty.
REQ-016 SHALL use the states IDLE, START, DATA, PARITY, STOP.
- IDLE to START when the buffer is full; START to DATA; DATA to PARITY, or to STOP when PARITY is 0; PARITY to STOP.
- STOP to START when the buffer is full, otherwise STOP to IDLE.
REQ-017 SHALL move the buffered word into a shift register when entering START, and SHALL empty the buffer on that same cycle.
REQ-018 SHALL drive o_tx_serial low on the cycle after acceptance when the block is IDLE (latency of 1 cycle).
REQ-019 SHALL hold every serial bit for exactly CLKS_PER_BIT cycles.
REQ-020 SHALL send data bits LSB first.
REQ-021 SHALL send the parity bit as the XOR of the data bits for even parity, and as its inverse for odd parity.
REQ-022 SHALL hold the line high for STOP_BITS times CLKS_PER_BIT cycles during STOP.
REQ-023 SHALL accept a word while a frame is in progress if the buffer is empty; that frame's start bit SHALL follow the last stop cycle directly, with no idle cycle between frames.
REQ-024 SHALL, when i_valid is high on the same cycle the buffer empties into START, show o_ready low on that cycle; the word is accepted on the next cycle.
REQ-025 SHALL drive o_tx_busy high in START, DATA, PARITY and STOP, and low in IDLE.
REQ-026 SHALL pulse o_tx_done on the final cycle of the last stop bit, including when a back-to-back frame follows.
REQ-027 SHALL count bits with a bit counter that covers 0..DATA_BITS-1 with no wrap outside that range; the cycle counter SHALL be $clog2(CLKS_PER_BIT) bits wide and reset to 0 at each bit boundary.
REQ-028 SHALL hold o_tx_serial high in IDLE and after any illegal state encoding, and SHALL recover to IDLE.
REQ-029 SHALL fail at elaboration if any parameter is outside its legal range.

Reset
REQ-030 SHALL, while rst is low, force o_tx_serial=1, o_ready=1, o_tx_busy=0, o_tx_done=0 and o_tick_debug=0, and SHALL set state to IDLE, clear all counters and empty the buffer.
REQ-031 SHALL, on reset mid-frame, abort the frame at once with the line high; no o_tx_done pulse is produced.
REQ-032 SHALL allow the first acceptance on the first rising edge after rst goes high.

Structure
REQ-033 SHALL take tx_cfg_state_t (IDLE..STOP) and the parity encoding constants from the shared typedefs package.
REQ-034 SHALL place the bit-period counter and tick generation in sub-module uart_baud_tick, parametrised by CLKS_PER_BIT, with a restart input and a tick output.

Verification
REQ-035 SHALL check CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1 sending 0xA5 -> line reads 0,1,0,1,0,0,1,0,1,1 (one value per 4 cycles), 40 cycles in total, with one o_tx_done pulse.
REQ-036 SHALL check PARITY=1 and PARITY=2 sending 0x07 -> parity bit is 1 for even and 0 for odd.
REQ-037 SHALL check DATA_BITS=5, STOP_BITS=2 sending 0x1F -> frame is 1+5+2 bits = 32 cycles at CLKS_PER_BIT=4.
REQ-038 SHALL check back-to-back sending of 0x55 then 0x33 with i_valid held -> second start bit begins on the cycle after the first stop bit ends, o_ready drops while the buffer is full, and two o_tx_done pulses occur 40 cycles apart.
REQ-039 SHALL check rst asserted during data bit 3 -> line goes high immediately, o_ready=1, no o_tx_done, and a new 0x81 frame is sent correctly after release.
REQ-040 SHALL check i_valid held high with o_ready low -> no second acceptance and no data corruption.
